mem_wb_stage_ml: RTL

- Parametrised successor of the MIPS pipeline MEM/WB stage.
- Adds byte/half/word loads and stores with sign or zero extension, a data memory with configurable wait states, and a stall handshake back to EX/MEM.
- Adds a flush input and misalignment detection.
- Sits between the EX/MEM register and the register-file write-back mux; its outputs feed write-back and forwarding.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_wb_stage_ml_if.sv | 26 ++
 rtl/data_mem_be.sv | 18 +
 rtl/mem_wb_stage_ml.sv | 84 ++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, stage FSM states and byte-lane helpers for the MEM/WB stage.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, BUSY} stateT;

    // The reserved size 2'b11 falls through to the word case everywhere.
    function automatic logic [3:0] byteEn(input logic [1:0] size, input logic [1:0] lane);
        return size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? 4'b0011 << lane : 4'b1111;
    endfunction

    function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
        return size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
    endfunction

    function automatic logic [31:0] loadExt(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic isUnsigned);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        return size == SZ_BYTE ? {{24{~isUnsigned & sh[7]}}, sh[7:0]} :
               size == SZ_HALF ? {{16{~isUnsigned & sh[15]}}, sh[15:0]} : word;
    endfunction
endpackage

// File: rtl/mem_wb_stage_ml_if.sv
// mem_wb_stage_ml_if: EX/MEM control and data in, stall back, MEM/WB register outputs.
interface mem_wb_stage_ml_if #(parameter int DATA_W = 32, parameter int REG_ADDR_W = 5);
    logic                  in_valid, RegWrite, memWrite, memRead, memtoReg, mem_unsigned, flush;
    logic [1:0]            mem_size;
    logic [REG_ADDR_W-1:0] regWriteDst;
    logic [DATA_W-1:0]     out_ALU, memWriteData;
    logic                  stall_MEM, out_valid_MEMWB, out_reg_RegWrite_MEMWB, out_reg_memtoReg_MEMWB;
    logic                  out_misalign_MEMWB;
    logic [REG_ADDR_W-1:0] out_reg_regWriteDst_MEMWB;
    logic [DATA_W-1:0]     out_reg_memoryData_MEMWB, writeDataRegFile_MEMWB;

    modport master (
        output in_valid, RegWrite, memWrite, memRead, memtoReg, mem_unsigned, flush,
               mem_size, regWriteDst, out_ALU, memWriteData,
        input  stall_MEM, out_valid_MEMWB, out_reg_RegWrite_MEMWB, out_reg_memtoReg_MEMWB,
               out_misalign_MEMWB, out_reg_regWriteDst_MEMWB, out_reg_memoryData_MEMWB,
               writeDataRegFile_MEMWB
    );
    modport slave (
        input  in_valid, RegWrite, memWrite, memRead, memtoReg, mem_unsigned, flush,
               mem_size, regWriteDst, out_ALU, memWriteData,
        output stall_MEM, out_valid_MEMWB, out_reg_RegWrite_MEMWB, out_reg_memtoReg_MEMWB,
               out_misalign_MEMWB, out_reg_regWriteDst_MEMWB, out_reg_memoryData_MEMWB,
               writeDataRegFile_MEMWB
    );
endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: word-organised RAM with per-byte write enables, synchronous write and asynchronous read.
module data_mem_be #(parameter int DEPTH = 256) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];

    // Asynchronous read gives the pre-store word when a load and store coincide.
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_wb_stage_ml.sv
// mem_wb_stage_ml: MEM stage with sized loads/stores, wait-state FSM and stall, plus the MEM/WB register.
module mem_wb_stage_ml import mem_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 256,
    parameter int MEM_LAT    = 0
) (
    input logic              clk,
    input logic              rst,
    mem_wb_stage_ml_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    stateT                 state, nextState;
    logic [2:0]            cnt, nextCnt;
    logic [1:0]            lane;
    logic                  misalign, memOp, needWait, accept, we;
    logic [DATA_W-1:0]     rdata, loadData;
    logic [REG_ADDR_W-1:0] wbDst;

    assign lane     = bus.out_ALU[1:0];
    assign misalign = (bus.mem_size == SZ_HALF && lane[0]) || (bus.mem_size[1] && lane != 2'b00);
    assign memOp    = bus.in_valid && (bus.memRead || bus.memWrite) && !misalign;
    assign needWait = MEM_LAT > 0 && memOp;
    // An instruction retires when unflushed and either needs no wait or is in its last busy cycle.
    assign accept   = !bus.flush && bus.in_valid && (state == BUSY ? cnt == 3'd1 : !needWait);
    assign we       = accept && bus.memWrite && !misalign;
    assign loadData = accept && bus.memRead && !misalign ? loadExt(rdata, bus.mem_size, lane, bus.mem_unsigned) : '0;
    assign wbDst    = accept ? bus.regWriteDst : '0;

    data_mem_be #(.DEPTH(DEPTH)) uMem (
        .clk   (clk),
        .we    (we),
        .be    (byteEn(bus.mem_size, lane)),
        .addr  (bus.out_ALU[AW+1:2]),
        .wdata (storeData(bus.mem_size, bus.memWriteData)),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        if (bus.flush) begin
            nextState = IDLE;
            nextCnt   = '0;
        end else if (state == IDLE && needWait) begin
            nextState = BUSY;
            nextCnt   = 3'(MEM_LAT);
        end else if (state == BUSY) begin
            nextState = cnt > 3'd1 ? BUSY : IDLE;
            nextCnt   = cnt - 3'd1;
        end
    end

    always_comb bus.stall_MEM = rst && !bus.flush && (state == BUSY ? cnt > 3'd1 : needWait);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.out_valid_MEMWB           <= 1'b0;
            bus.out_reg_RegWrite_MEMWB    <= 1'b0;
            bus.out_reg_memtoReg_MEMWB    <= 1'b0;
            bus.out_reg_regWriteDst_MEMWB <= '0;
            bus.out_reg_memoryData_MEMWB  <= '0;
            bus.writeDataRegFile_MEMWB    <= '0;
            bus.out_misalign_MEMWB        <= 1'b0;
        end else begin
            bus.out_valid_MEMWB           <= accept;
            bus.out_reg_RegWrite_MEMWB    <= accept && bus.RegWrite && !misalign;
            bus.out_reg_memtoReg_MEMWB    <= accept && bus.memtoReg;
            bus.out_reg_regWriteDst_MEMWB <= wbDst;
            bus.out_reg_memoryData_MEMWB  <= loadData;
            bus.writeDataRegFile_MEMWB    <= accept ? bus.out_ALU : '0;
            bus.out_misalign_MEMWB        <= accept && misalign;
        end
endmodule
